mem_access: RTL and testbench

//  Memory-access stage directly downstream of the cushion register stage.
//  - Turns the registered load/store request into a valid/ready data-bus transaction and waits for the response.
//  - Aligns and sign/zero-extends load data.
//  - Merges load results with plain ALU register writes into one registered writeback.
//  - Holds the cushion stage (STALL) while a bus access is outstanding.

---
 rtl/mem_access.sv | 191 +++++++++++++++++++
 tb/tb_mem_access.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//   Memory-access stage that sits directly behind the cushion register stage.
//   A registered load/store request from the cushion becomes a valid/ready
//   data-bus transaction. The stage then waits for the single-cycle response
//   or gives up after TIMEOUT cycles. Load data is aligned and sign/zero-
//   extended, then merged with plain ALU writes into one registered writeback.
//   While an access is outstanding, MEMR_STALL holds the cushion stage.
//
// Parameters
//   TIMEOUT  maximum cycles spent in WAIT before a forced completion
//            (0 = never time out)
//
// Ports
//   CLK, RST                 clock (rising edge), asynchronous active-low reset
//   CUSHION_REG_W_RD/DATA    ALU writeback request (rd 0 = none)
//   CUSHION_MEM_R_*          load request: valid, rd, addr, strb, signed
//   CUSHION_MEM_W_*          store request: valid, addr, strb, data
//   DBUS_REQ_*               bus request channel (valid/ready, we, addr, strb, wdata)
//   DBUS_RESP_VALID/RDATA    bus response pulse and full-word read data
//   MEMR_STALL               hold for the cushion stage (combinational)
//   MEMR_REG_W_RD/DATA       registered writeback
//   MEMR_BUS_ERR             one-cycle pulse when an access times out
// -----------------------------------------------------------------------------
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  CUSHION_REG_W_RD,
  input  logic [31:0] CUSHION_REG_W_DATA,
  input  logic        CUSHION_MEM_R_VALID,
  input  logic [4:0]  CUSHION_MEM_R_RD,
  input  logic [31:0] CUSHION_MEM_R_ADDR,
  input  logic [3:0]  CUSHION_MEM_R_STRB,
  input  logic        CUSHION_MEM_R_SIGNED,
  input  logic        CUSHION_MEM_W_VALID,
  input  logic [31:0] CUSHION_MEM_W_ADDR,
  input  logic [3:0]  CUSHION_MEM_W_STRB,
  input  logic [31:0] CUSHION_MEM_W_DATA,
  output logic        DBUS_REQ_VALID,
  input  logic        DBUS_REQ_READY,
  output logic        DBUS_REQ_WE,
  output logic [31:0] DBUS_REQ_ADDR,
  output logic [3:0]  DBUS_REQ_STRB,
  output logic [31:0] DBUS_REQ_WDATA,
  input  logic        DBUS_RESP_VALID,
  input  logic [31:0] DBUS_RESP_RDATA,
  output logic        MEMR_STALL,
  output logic [4:0]  MEMR_REG_W_RD,
  output logic [31:0] MEMR_REG_W_DATA,
  output logic        MEMR_BUS_ERR
);

  // The counter only has to reach TIMEOUT-1.
  localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_op;
  logic             w_req_valid;
  logic             w_complete;
  logic             w_timeout;

  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_data;
  logic             r_bus_err;
  logic [4:0]       w_wb_rd_nxt;
  logic [31:0]      w_wb_data_nxt;

  // Load extraction: shift the addressed byte to lane 0, then choose the
  // width from the byte-enable popcount. Illegal strobes fall back to a word.
  function automatic logic [31:0] load_extract(
    input logic [31:0] rdata,
    input logic [1:0]  off,
    input logic [3:0]  strb,
    input logic        sgn
  );
    logic [31:0] sh;
    logic [2:0]  n;
    sh = rdata >> {off, 3'b000};
    n  = 3'(strb[0]) + 3'(strb[1]) + 3'(strb[2]) + 3'(strb[3]);
    case (n)
      3'd1:    return {{24{sgn & sh[7]}}, sh[7:0]};
      3'd2:    return {{16{sgn & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // The load wins when both requests are present. The store is then dropped.
  assign w_op           = CUSHION_MEM_R_VALID | CUSHION_MEM_W_VALID;
  assign DBUS_REQ_WE    = CUSHION_MEM_W_VALID & ~CUSHION_MEM_R_VALID;
  assign DBUS_REQ_ADDR  = CUSHION_MEM_R_VALID ? CUSHION_MEM_R_ADDR : CUSHION_MEM_W_ADDR;
  assign DBUS_REQ_STRB  = CUSHION_MEM_R_VALID ? CUSHION_MEM_R_STRB : CUSHION_MEM_W_STRB;
  assign DBUS_REQ_WDATA = CUSHION_MEM_R_VALID ? 32'd0 : CUSHION_MEM_W_DATA;

  // During reset, request and stall are held low.
  assign DBUS_REQ_VALID = RST & w_req_valid;
  assign MEMR_STALL     = RST & w_op & ~w_complete;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_valid = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_valid = w_op;
        w_cnt_nxt   = '0;
        if (w_op && DBUS_REQ_READY) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // If the response and the timeout come in the same cycle, the response wins.
        if (DBUS_RESP_VALID) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          w_complete  = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Writeback selection. A pending access inserts a bubble (rd 0). Without
  // an access, the ALU write passes through with one cycle of latency.
  always_comb begin
    w_wb_rd_nxt   = CUSHION_REG_W_RD;
    w_wb_data_nxt = CUSHION_REG_W_DATA;
    if (w_complete) begin
      if (CUSHION_MEM_R_VALID) begin
        w_wb_rd_nxt   = CUSHION_MEM_R_RD;
        w_wb_data_nxt = w_timeout ? 32'd0
                      : load_extract(DBUS_RESP_RDATA, CUSHION_MEM_R_ADDR[1:0],
                                     CUSHION_MEM_R_STRB, CUSHION_MEM_R_SIGNED);
      end else begin
        w_wb_rd_nxt   = 5'd0;
        w_wb_data_nxt = 32'd0;
      end
    end else if (w_op) begin
      w_wb_rd_nxt   = 5'd0;
      w_wb_data_nxt = 32'd0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_wb_rd   <= w_wb_rd_nxt;
      r_wb_data <= w_wb_data_nxt;
      r_bus_err <= w_timeout;
    end
  end

  assign MEMR_REG_W_RD   = r_wb_rd;
  assign MEMR_REG_W_DATA = r_wb_data;
  assign MEMR_BUS_ERR    = r_bus_err;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  CUSHION_REG_W_RD;
  logic [31:0] CUSHION_REG_W_DATA;
  logic        CUSHION_MEM_R_VALID;
  logic [4:0]  CUSHION_MEM_R_RD;
  logic [31:0] CUSHION_MEM_R_ADDR;
  logic [3:0]  CUSHION_MEM_R_STRB;
  logic        CUSHION_MEM_R_SIGNED;
  logic        CUSHION_MEM_W_VALID;
  logic [31:0] CUSHION_MEM_W_ADDR;
  logic [3:0]  CUSHION_MEM_W_STRB;
  logic [31:0] CUSHION_MEM_W_DATA;
  logic        DBUS_REQ_VALID;
  logic        DBUS_REQ_READY;
  logic        DBUS_REQ_WE;
  logic [31:0] DBUS_REQ_ADDR;
  logic [3:0]  DBUS_REQ_STRB;
  logic [31:0] DBUS_REQ_WDATA;
  logic        DBUS_RESP_VALID;
  logic [31:0] DBUS_RESP_RDATA;
  logic        MEMR_STALL;
  logic [4:0]  MEMR_REG_W_RD;
  logic [31:0] MEMR_REG_W_DATA;
  logic        MEMR_BUS_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access #(.TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .CUSHION_REG_W_RD(CUSHION_REG_W_RD), .CUSHION_REG_W_DATA(CUSHION_REG_W_DATA),
    .CUSHION_MEM_R_VALID(CUSHION_MEM_R_VALID), .CUSHION_MEM_R_RD(CUSHION_MEM_R_RD),
    .CUSHION_MEM_R_ADDR(CUSHION_MEM_R_ADDR), .CUSHION_MEM_R_STRB(CUSHION_MEM_R_STRB),
    .CUSHION_MEM_R_SIGNED(CUSHION_MEM_R_SIGNED),
    .CUSHION_MEM_W_VALID(CUSHION_MEM_W_VALID), .CUSHION_MEM_W_ADDR(CUSHION_MEM_W_ADDR),
    .CUSHION_MEM_W_STRB(CUSHION_MEM_W_STRB), .CUSHION_MEM_W_DATA(CUSHION_MEM_W_DATA),
    .DBUS_REQ_VALID(DBUS_REQ_VALID), .DBUS_REQ_READY(DBUS_REQ_READY),
    .DBUS_REQ_WE(DBUS_REQ_WE), .DBUS_REQ_ADDR(DBUS_REQ_ADDR),
    .DBUS_REQ_STRB(DBUS_REQ_STRB), .DBUS_REQ_WDATA(DBUS_REQ_WDATA),
    .DBUS_RESP_VALID(DBUS_RESP_VALID), .DBUS_RESP_RDATA(DBUS_RESP_RDATA),
    .MEMR_STALL(MEMR_STALL), .MEMR_REG_W_RD(MEMR_REG_W_RD),
    .MEMR_REG_W_DATA(MEMR_REG_W_DATA), .MEMR_BUS_ERR(MEMR_BUS_ERR)
  );

  always #5 CLK = ~CLK;

  // Reference: value a load returns, from plain arithmetic on byte positions.
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [3:0] strb, input logic sgn);
    longint unsigned v;
    int nbytes;
    int ones;
    ones = 0;
    for (int i = 0; i < 4; i++) if (strb[i]) ones++;
    nbytes = (ones == 1) ? 1 : (ones == 2) ? 2 : 4;
    v = longint'(rdata) / (64'd1 << (8 * (addr % 4)));
    v = v % (64'd1 << (8 * nbytes));
    if (sgn && nbytes < 4 && v >= (64'd1 << (8 * nbytes - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * nbytes));
    return v[31:0];
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    CUSHION_MEM_R_VALID = 0; CUSHION_MEM_W_VALID = 0;
    DBUS_REQ_READY = 0; DBUS_RESP_VALID = 0; DBUS_RESP_RDATA = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    CUSHION_REG_W_RD = 5'd7; CUSHION_REG_W_DATA = 32'hDEAD;
    CUSHION_MEM_R_RD = 0; CUSHION_MEM_R_ADDR = 0; CUSHION_MEM_R_STRB = 0; CUSHION_MEM_R_SIGNED = 0;
    CUSHION_MEM_W_ADDR = 0; CUSHION_MEM_W_STRB = 0; CUSHION_MEM_W_DATA = 0;
    RST = 0;
    CUSHION_MEM_R_VALID = 1;  // the request must still be masked during reset
    step(); step();
    n_checks++;
    if (MEMR_REG_W_RD !== 0 || MEMR_REG_W_DATA !== 0 || MEMR_BUS_ERR !== 0 ||
        DBUS_REQ_VALID !== 0 || MEMR_STALL !== 0) begin
      n_fail++;
      $display("FAIL reset: rd=%0d data=%h err=%b reqv=%b stall=%b, required all 0",
               MEMR_REG_W_RD, MEMR_REG_W_DATA, MEMR_BUS_ERR, DBUS_REQ_VALID, MEMR_STALL);
    end
    CUSHION_MEM_R_VALID = 0;
    @(negedge CLK); RST = 1;
    step();
  endtask

  task automatic test_alu_pass(input int n);
    for (int i = 0; i < n; i++) begin
      logic [4:0] rd; logic [31:0] d;
      rd = (i == 0) ? 5'd5 : 5'($urandom);
      d  = (i == 0) ? 32'h1234 : $urandom;
      CUSHION_REG_W_RD = rd; CUSHION_REG_W_DATA = d;
      #1;
      n_checks++;
      if (MEMR_STALL !== 0 || DBUS_REQ_VALID !== 0) begin
        n_fail++;
        $display("FAIL alu_stall: stall=%b reqv=%b, required 0 0", MEMR_STALL, DBUS_REQ_VALID);
      end
      step();
      n_checks++;
      if (MEMR_REG_W_RD !== rd || MEMR_REG_W_DATA !== d) begin
        n_fail++;
        $display("FAIL alu_pass: rd=%0d data=%h, required rd=%0d data=%h", MEMR_REG_W_RD, MEMR_REG_W_DATA, rd, d);
      end
    end
  endtask

  // One complete access. ready_dly is the number of cycles with READY low.
  // resp_dly is the WAIT cycle (1-based) that carries the response.
  task automatic do_access(input bit is_load, input bit also_store, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [3:0] strb, input bit sgn,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int ready_dly, input int resp_dly);
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    bit          exp_we;
    CUSHION_REG_W_RD = 5'($urandom); CUSHION_REG_W_DATA = $urandom;
    CUSHION_MEM_R_VALID = is_load; CUSHION_MEM_R_RD = rd; CUSHION_MEM_R_ADDR = addr;
    CUSHION_MEM_R_STRB = strb; CUSHION_MEM_R_SIGNED = sgn;
    CUSHION_MEM_W_VALID = !is_load || also_store;
    CUSHION_MEM_W_ADDR = is_load ? ~addr : addr;
    CUSHION_MEM_W_STRB = is_load ? ~strb : strb;
    CUSHION_MEM_W_DATA = wdata;
    exp_we    = !is_load;
    exp_wdata = is_load ? 32'd0 : wdata;
    exp_data  = model_load(rdata, addr, strb, sgn);
    for (int c = 0; c <= ready_dly; c++) begin
      DBUS_REQ_READY = (c == ready_dly);
      #1;
      n_checks++;
      if (DBUS_REQ_VALID !== 1 || DBUS_REQ_WE !== exp_we || DBUS_REQ_ADDR !== addr ||
          DBUS_REQ_STRB !== strb || DBUS_REQ_WDATA !== exp_wdata || MEMR_STALL !== 1) begin
        n_fail++;
        $display("FAIL request: v=%b we=%b a=%h s=%b wd=%h st=%b, required 1 %b %h %b %h 1",
                 DBUS_REQ_VALID, DBUS_REQ_WE, DBUS_REQ_ADDR, DBUS_REQ_STRB, DBUS_REQ_WDATA,
                 MEMR_STALL, exp_we, addr, strb, exp_wdata);
      end
      step();
      n_checks++;
      if (MEMR_REG_W_RD !== 0) begin
        n_fail++;
        $display("FAIL bubble_req: rd=%0d, required 0", MEMR_REG_W_RD);
      end
    end
    DBUS_REQ_READY = 0;
    for (int w = 1; w <= resp_dly; w++) begin
      DBUS_RESP_VALID = (w == resp_dly);
      DBUS_RESP_RDATA = (w == resp_dly) ? rdata : $urandom;
      #1;
      n_checks++;
      if (DBUS_REQ_VALID !== 0 || MEMR_STALL !== (w != resp_dly)) begin
        n_fail++;
        $display("FAIL wait: reqv=%b stall=%b, required 0 %b", DBUS_REQ_VALID, MEMR_STALL, w != resp_dly);
      end
      step();
      DBUS_RESP_VALID = 0;
      if (w == resp_dly) begin
        // The cushion advances on the completion edge.
        CUSHION_MEM_R_VALID = 0; CUSHION_MEM_W_VALID = 0;
        n_checks++;
        if (is_load && (MEMR_REG_W_RD !== rd || MEMR_REG_W_DATA !== exp_data)) begin
          n_fail++;
          $display("FAIL load_wb: rd=%0d data=%h, required rd=%0d data=%h", MEMR_REG_W_RD, MEMR_REG_W_DATA, rd, exp_data);
        end else if (!is_load && MEMR_REG_W_RD !== 0) begin
          n_fail++;
          $display("FAIL store_wb: rd=%0d, required 0", MEMR_REG_W_RD);
        end
        n_checks++;
        if (MEMR_BUS_ERR !== 0) begin
          n_fail++;
          $display("FAIL no_err: bus_err=%b, required 0", MEMR_BUS_ERR);
        end
      end else begin
        n_checks++;
        if (MEMR_REG_W_RD !== 0) begin
          n_fail++;
          $display("FAIL bubble_wait: rd=%0d, required 0", MEMR_REG_W_RD);
        end
      end
    end
  endtask

  task automatic test_directed();
    do_access(1, 0, 5'd9,  32'h102, 4'b0100, 1, 32'h0, 32'h0080_0000, 0, 3);
    do_access(1, 0, 5'd10, 32'h2,   4'b1100, 0, 32'h0, 32'hBEEF_0000, 0, 1);
    do_access(1, 0, 5'd11, 32'h2,   4'b1100, 1, 32'h0, 32'hBEEF_0000, 1, 2);
    do_access(0, 0, 5'd12, 32'h40,  4'b0011, 0, 32'h0000_A5A5, 32'h0, 4, 2);
    do_access(1, 1, 5'd13, 32'h80,  4'b1111, 1, 32'h1111_2222, 32'h8765_4321, 0, 1);
  endtask

  task automatic test_random(input int n);
    logic [3:0] strbs [7];
    strbs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    for (int i = 0; i < n; i++) begin
      logic [3:0] s; logic [31:0] a; int k;
      k = $urandom_range(0, 6);
      s = strbs[k];
      a = {$urandom, 2'b00} >> 2;
      a[1:0] = (k < 4) ? 2'(k) : (k == 5) ? 2'd2 : 2'd0;
      do_access($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 5'($urandom_range(1, 31)),
                a, s, $urandom_range(0, 1) == 1, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(1, 5));
      if ($urandom_range(0, 1) == 1) test_alu_pass(1);
    end
  endtask

  task automatic test_timeout();
    int err_cycles;
    err_cycles = 0;
    CUSHION_MEM_R_VALID = 1; CUSHION_MEM_W_VALID = 0; CUSHION_MEM_R_RD = 5'd17;
    CUSHION_MEM_R_ADDR = 32'h200; CUSHION_MEM_R_STRB = 4'b1111; CUSHION_MEM_R_SIGNED = 0;
    DBUS_REQ_READY = 1;
    step();  // acceptance edge
    DBUS_REQ_READY = 0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      n_checks++;
      if (MEMR_STALL !== (c != 8)) begin
        n_fail++;
        $display("FAIL timeout_stall: cycle %0d stall=%b, required %b", c, MEMR_STALL, c != 8);
      end
      step();
      if (MEMR_BUS_ERR === 1) err_cycles++;
      if (c < 8) begin
        n_checks++;
        if (MEMR_BUS_ERR !== 0) begin
          n_fail++;
          $display("FAIL timeout_early: cycle %0d bus_err=%b, required 0", c, MEMR_BUS_ERR);
        end
      end
    end
    CUSHION_MEM_R_VALID = 0;
    n_checks++;
    if (MEMR_BUS_ERR !== 1 || MEMR_REG_W_RD !== 5'd17 || MEMR_REG_W_DATA !== 0) begin
      n_fail++;
      $display("FAIL timeout_wb: err=%b rd=%0d data=%h, required 1 17 0", MEMR_BUS_ERR, MEMR_REG_W_RD, MEMR_REG_W_DATA);
    end
    // A late response must be ignored, and the ALU write passes.
    CUSHION_REG_W_RD = 5'd3; CUSHION_REG_W_DATA = 32'hCAFE;
    DBUS_RESP_VALID = 1; DBUS_RESP_RDATA = 32'h1234_5678;
    step();
    DBUS_RESP_VALID = 0;
    if (MEMR_BUS_ERR === 1) err_cycles++;
    n_checks++;
    if (err_cycles !== 1 || MEMR_REG_W_RD !== 5'd3 || MEMR_REG_W_DATA !== 32'hCAFE || DBUS_REQ_VALID !== 0) begin
      n_fail++;
      $display("FAIL late_resp: err_cycles=%0d rd=%0d data=%h reqv=%b, required 1 3 cafe 0",
               err_cycles, MEMR_REG_W_RD, MEMR_REG_W_DATA, DBUS_REQ_VALID);
    end
  endtask

  task automatic test_reset_mid_wait();
    CUSHION_MEM_R_VALID = 1; CUSHION_MEM_R_RD = 5'd21; CUSHION_MEM_R_ADDR = 32'h300;
    CUSHION_MEM_R_STRB = 4'b0001; CUSHION_MEM_R_SIGNED = 1;
    DBUS_REQ_READY = 1;
    step();
    DBUS_REQ_READY = 0;
    step();
    #2 RST = 0;
    #1;
    n_checks++;
    if (MEMR_REG_W_RD !== 0 || MEMR_REG_W_DATA !== 0 || MEMR_BUS_ERR !== 0 ||
        DBUS_REQ_VALID !== 0 || MEMR_STALL !== 0) begin
      n_fail++;
      $display("FAIL reset_mid: rd=%0d data=%h err=%b reqv=%b stall=%b, required all 0",
               MEMR_REG_W_RD, MEMR_REG_W_DATA, MEMR_BUS_ERR, DBUS_REQ_VALID, MEMR_STALL);
    end
    @(negedge CLK); RST = 1;
    CUSHION_MEM_R_VALID = 0;
    step();
    do_access(1, 0, 5'd22, 32'h301, 4'b0010, 1, 32'h0, 32'h0000_F000, 0, 2);
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_alu_pass(4);
    test_directed();
    test_random(25);
    test_timeout();
    test_reset_mid_wait();
    test_alu_pass(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
